gate_bist: RTL and testbench
============================

# gate_bist

Synthesizable exhaustive-pattern tester for the basic-gate library. It drives every input combination into a combinational gate under test and compares the gate's output against a parameterized truth table. It reports pass/fail, the mismatch count and the first failing vector. It sits beside a gate instance as the hardware counterpart to the team's simulation truth-table benches, for on-silicon or FPGA self-check.

## Interface
- `N_IN`, 2: number of gate inputs; legal range 1–4.
- `TRUTH`, 4'b1000: expected output per input vector; bit `i` = expected `Y` for `dut_in == i`; width `2**N_IN`; default = 2-input AND.
- `SETTLE`, 1: cycles each vector is held before sampling; must be ≥ 1.
- `clk`  in  1  sole clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a sweep; sampled only in IDLE or DONE.
- `dut_y`  in  1  output of gate under test.
- `dut_in`  out  N_IN  registered vector driven to gate inputs; reset 0.
- `busy`  out  1  high from the cycle after accepted `start` until DONE; reset 0.
- `done`  out  1  level, high in DONE until next accepted `start`; reset 0.
- `pass`  out  1  valid while `done`; 1 iff `err_count == 0`; reset 0.
- `err_count`  out  N_IN+1  mismatches in last sweep; saturates at `2**N_IN`; reset 0.
- `fail_vec`  out  N_IN  first mismatching vector of last sweep; 0 if none; reset 0.

## Operation
- FSM states: IDLE, WAIT, CHECK, DONE. Reset state: IDLE.
- IDLE, `start`=1: `dut_in`←0, `err_count`←0, `fail_vec`←0, wait counter←0 → WAIT.
- WAIT: hold `dut_in`; counter increments; after `SETTLE` cycles in WAIT → CHECK.
- CHECK: compare `dut_y` with `TRUTH[dut_in]`.
  - On mismatch: `err_count`++.
  - On mismatch with `err_count` == 0: `fail_vec`←`dut_in`.
  - If `dut_in == 2**N_IN-1` → DONE.
  - Otherwise `dut_in`++, counter←0 → WAIT.
- DONE: `done`=1, `busy`=0, `pass`=(`err_count`==0); `dut_in` holds last vector.
- DONE, `start`=1: same actions as IDLE+`start` (clears results, `done`→0 next cycle).
- `start` during WAIT/CHECK: ignored; no restart, no effect on results.
- `dut_in` never wraps mid-sweep; the last vector is terminal.
- `rst_n` low at any time: all outputs to reset values at once, state → IDLE; the sweep in progress is abandoned with no partial report.

## Timing
- Cycle 0: `start` sampled high in IDLE/DONE.
- Cycle 1: first WAIT cycle; `dut_in`=0, `busy`=1.
- Each vector occupies `SETTLE`+1 cycles (WAIT ×`SETTLE`, CHECK ×1).
- `done` rises at cycle 1 + `2**N_IN`·(`SETTLE`+1); defaults give cycle 9.
- `dut_y` is sampled on the clock edge ending the CHECK cycle. The gate path from `dut_in` must meet `SETTLE`+1 cycles.
- `err_count`/`fail_vec` update on the edge ending CHECK; final values are stable when `done` rises.

## Configuration
- `GATE_BIST_STOP_ON_FAIL_EN` defined:
  - The first mismatch in CHECK goes straight to DONE with `err_count`=1, `fail_vec`=that vector, `pass`=0.
  - `dut_in` holds the failing vector.
  - `done` latency shrinks accordingly.
- Not defined: the sweep always covers all `2**N_IN` vectors and counts every mismatch.

## Test plan
- Defaults, `dut_y` = `dut_in[1]&dut_in[0]`; pulse `start` → `done` at cycle 9, `pass`=1, `err_count`=0, `fail_vec`=0; `dut_in` sequence 0,1,2,3 (2 cycles each).
- Defaults, `dut_y` tied 0 → `pass`=0, `err_count`=1, `fail_vec`=3.
- Defaults, `dut_y` tied 1 → `err_count`=3, `fail_vec`=0.
  - With `GATE_BIST_STOP_ON_FAIL_EN`: `done` at cycle 3, `err_count`=1, `fail_vec`=0.
- `N_IN`=3, `TRUTH`=8'h96, `SETTLE`=2, `dut_y` = 3-input XOR → `done` at cycle 25, `pass`=1.
- `start` re-pulsed at cycle 4 of a default sweep → ignored, `done` still at cycle 9; `start` in DONE → `done` low next cycle, new sweep ends 9 cycles later.
- `rst_n` low at cycle 5 of a sweep → same-instant `busy`=0, `dut_in`=0, `err_count`=0; after release, `start` → normal completion at cycle 9.

Source files
------------

// File: rtl/gate_bist.sv
// gate_bist: exhaustive-pattern self-test for a single combinational gate.
// Walks every input vector 0 .. 2**N_IN-1 into the gate under test, holds
// each for SETTLE cycles, then compares the gate output against TRUTH.
// Reports pass/fail, the mismatch count and the first failing vector.
//
// Parameters:
//   N_IN    number of gate inputs (1..4)
//   TRUTH   expected output per vector; bit i = expected Y for vector i
//   SETTLE  cycles each vector is held before sampling (>= 1)
//
// Ports:
//   i_clk        sole clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_start      begin a sweep (honoured only in IDLE or DONE)
//   i_dut_y      output of the gate under test
//   o_dut_in     registered vector driven to the gate inputs
//   o_busy       sweep in progress (WAIT/CHECK)
//   o_done       level, high in DONE until the next accepted start
//   o_pass       high in DONE when no mismatch was seen
//   o_err_count  mismatches in the last sweep, saturating at 2**N_IN
//   o_fail_vec   first mismatching vector of the last sweep, 0 if none
//
// Build option:
//   GATE_BIST_STOP_ON_FAIL_EN  when defined, the first mismatch ends the
//                              sweep immediately and dut_in holds the
//                              failing vector.

module gate_bist #(
   parameter int unsigned               N_IN   = 2,
   parameter logic [(1 << N_IN) - 1:0]  TRUTH  = 4'b1000,
   parameter int unsigned               SETTLE = 1
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_start,
   input  logic            i_dut_y,
   output logic [N_IN-1:0] o_dut_in,
   output logic            o_busy,
   output logic            o_done,
   output logic            o_pass,
   output logic [N_IN:0]   o_err_count,
   output logic [N_IN-1:0] o_fail_vec
);

   localparam int unsigned NVEC = 1 << N_IN;
   // Settle counter runs 0 .. SETTLE-1; keep at least one bit.
   localparam int unsigned CW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
   localparam logic [N_IN:0] ERR_MAX  = (N_IN + 1)'(NVEC);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_CHECK = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [N_IN-1:0] r_dut_in;
   logic [N_IN-1:0] w_dut_in_nxt;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_nxt;
   logic [N_IN:0]   r_err;
   logic [N_IN:0]   w_err_nxt;
   logic [N_IN-1:0] r_fail;
   logic [N_IN-1:0] w_fail_nxt;

   logic            w_expected;
   logic            w_mismatch;
   logic            w_last_vec;

   assign w_expected = TRUTH[r_dut_in];
   assign w_mismatch = i_dut_y ^ w_expected;
   assign w_last_vec = &r_dut_in;

   // State and datapath registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= S_IDLE;
         r_dut_in <= '0;
         r_cnt    <= '0;
         r_err    <= '0;
         r_fail   <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_dut_in <= w_dut_in_nxt;
         r_cnt    <= w_cnt_nxt;
         r_err    <= w_err_nxt;
         r_fail   <= w_fail_nxt;
      end
   end

   // Next-state and datapath update
   always_comb begin
      w_state_nxt  = r_state;
      w_dut_in_nxt = r_dut_in;
      w_cnt_nxt    = r_cnt;
      w_err_nxt    = r_err;
      w_fail_nxt   = r_fail;

      case (r_state)
         S_IDLE, S_DONE: begin
            if (i_start) begin
               w_dut_in_nxt = '0;
               w_err_nxt    = '0;
               w_fail_nxt   = '0;
               w_cnt_nxt    = '0;
               w_state_nxt  = S_WAIT;
            end
         end

         S_WAIT: begin
            if (r_cnt == CNT_LAST) begin
               w_state_nxt = S_CHECK;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end

         S_CHECK: begin
            if (w_mismatch) begin
               // First failure is captured while the count is still zero.
               if (r_err == '0) begin
                  w_fail_nxt = r_dut_in;
               end
               if (r_err != ERR_MAX) begin
                  w_err_nxt = r_err + 1'b1;
               end
            end
`ifdef GATE_BIST_STOP_ON_FAIL_EN
            if (w_mismatch || w_last_vec) begin
               w_state_nxt = S_DONE;
            end else begin
               w_dut_in_nxt = r_dut_in + 1'b1;
               w_cnt_nxt    = '0;
               w_state_nxt  = S_WAIT;
            end
`else
            // Last vector is terminal: dut_in never wraps.
            if (w_last_vec) begin
               w_state_nxt = S_DONE;
            end else begin
               w_dut_in_nxt = r_dut_in + 1'b1;
               w_cnt_nxt    = '0;
               w_state_nxt  = S_WAIT;
            end
`endif
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Status is decoded from the state register so reset clears it at once.
   assign o_dut_in    = r_dut_in;
   assign o_busy      = (r_state == S_WAIT) || (r_state == S_CHECK);
   assign o_done      = (r_state == S_DONE);
   assign o_pass      = (r_state == S_DONE) && (r_err == '0);
   assign o_err_count = r_err;
   assign o_fail_vec  = r_fail;

endmodule

// File: tb/tb_gate_bist.sv
// tb_gate_bist: scoreboard bench for gate_bist.
// Two instances: defaults (2-input AND table, SETTLE=1) and a 3-input XOR
// table with SETTLE=2. A reference gate model drives i_dut_y; expected
// results are computed from the bench's own truth tables and pushed to a
// queue when start is driven, then popped when done rises.

module tb_gate_bist;

   typedef struct {
      int cyc;
      int pass;
      int err;
      int fvec;
      int last;
   } exp_t;

   localparam int M_AND  = 0;
   localparam int M_TIE0 = 1;
   localparam int M_TIE1 = 2;
   localparam int M_XOR  = 3;

   logic       clk;
   logic       rst_n;
   logic       start0, start1;
   logic       y0, y1;
   logic [1:0] d0_din;
   logic [2:0] d1_din;
   logic       d0_busy, d0_done, d0_pass;
   logic       d1_busy, d1_done, d1_pass;
   logic [2:0] d0_err;
   logic [3:0] d1_err;
   logic [1:0] d0_fvec;
   logic [2:0] d1_fvec;

   int mode0, mode1;
   int n_checks, n_errors;
   exp_t sb_q[$];

   gate_bist u_dut0 (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_start     (start0),
      .i_dut_y     (y0),
      .o_dut_in    (d0_din),
      .o_busy      (d0_busy),
      .o_done      (d0_done),
      .o_pass      (d0_pass),
      .o_err_count (d0_err),
      .o_fail_vec  (d0_fvec)
   );

   gate_bist #(
      .N_IN   (3),
      .TRUTH  (8'h96),
      .SETTLE (2)
   ) u_dut1 (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_start     (start1),
      .i_dut_y     (y1),
      .o_dut_in    (d1_din),
      .o_busy      (d1_busy),
      .o_done      (d1_done),
      .o_pass      (d1_pass),
      .o_err_count (d1_err),
      .o_fail_vec  (d1_fvec)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic gate_val(input int mode, input int v);
      logic [3:0] b;
      b = 4'(v);
      case (mode)
         M_AND:   return b[1] & b[0];
         M_TIE0:  return 1'b0;
         M_TIE1:  return 1'b1;
         default: return ^b;
      endcase
   endfunction

   always_comb y0 = gate_val(mode0, int'(d0_din));
   always_comb y1 = gate_val(mode1, int'(d1_din));

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int obs_din(input int w);
      return (w == 0) ? int'(d0_din) : int'(d1_din);
   endfunction
   function automatic int obs_busy(input int w);
      return (w == 0) ? int'(d0_busy) : int'(d1_busy);
   endfunction
   function automatic int obs_done(input int w);
      return (w == 0) ? int'(d0_done) : int'(d1_done);
   endfunction
   function automatic int obs_pass(input int w);
      return (w == 0) ? int'(d0_pass) : int'(d1_pass);
   endfunction
   function automatic int obs_err(input int w);
      return (w == 0) ? int'(d0_err) : int'(d1_err);
   endfunction
   function automatic int obs_fvec(input int w);
      return (w == 0) ? int'(d0_fvec) : int'(d1_fvec);
   endfunction

   function automatic int settle_of(input int w);
      return (w == 0) ? 1 : 2;
   endfunction

   // Reference result of a full sweep, from the bench's own truth tables.
   function automatic exp_t model(input int w, input int mode);
      exp_t       e;
      int         nvec;
      int         checked;
      logic [7:0] truth;
      nvec    = (w == 0) ? 4 : 8;
      truth   = (w == 0) ? 8'h08 : 8'h96;
      checked = nvec;
      e.err   = 0;
      e.fvec  = 0;
      e.last  = nvec - 1;
      for (int v = 0; v < nvec; v++) begin
         if (gate_val(mode, v) != truth[v]) begin
            if (e.err == 0) e.fvec = v;
            e.err++;
`ifdef GATE_BIST_STOP_ON_FAIL_EN
            checked = v + 1;
            e.last  = v;
            break;
`endif
         end
      end
      e.pass = (e.err == 0) ? 1 : 0;
      e.cyc  = 1 + checked * (settle_of(w) + 1);
      return e;
   endfunction

   task automatic set_start(input int w, input logic v);
      if (w == 0) start0 = v;
      else        start1 = v;
   endtask

   // Pulse start, follow the sweep cycle by cycle, score the result.
   task automatic run_sweep(input int w, input int mode, input bit restart_mid);
      exp_t e;
      int   cyc;
      int   s;
      s = settle_of(w);
      @(negedge clk);
      if (w == 0) mode0 = mode;
      else        mode1 = mode;
      sb_q.push_back(model(w, mode));
      set_start(w, 1'b1);
      @(negedge clk);
      set_start(w, 1'b0);
      cyc = 1;
      while (obs_done(w) == 0 && cyc < 300) begin
         check_eq("dut_in", obs_din(w), (cyc - 1) / (s + 1));
         check_eq("busy", obs_busy(w), 1);
         if (restart_mid && cyc == 4) set_start(w, 1'b1);
         @(negedge clk);
         set_start(w, 1'b0);
         cyc++;
      end
      e = sb_q.pop_front();
      check_eq("done_cycle", cyc, e.cyc);
      check_eq("busy_done", obs_busy(w), 0);
      check_eq("pass", obs_pass(w), e.pass);
      check_eq("err_count", obs_err(w), e.err);
      check_eq("fail_vec", obs_fvec(w), e.fvec);
      check_eq("dut_in_final", obs_din(w), e.last);
      @(negedge clk);
      check_eq("done_held", obs_done(w), 1);
      check_eq("pass_held", obs_pass(w), e.pass);
      check_eq("dut_in_held", obs_din(w), e.last);
   endtask

   task automatic check_reset_state(input int w);
      check_eq("rst_dut_in", obs_din(w), 0);
      check_eq("rst_busy", obs_busy(w), 0);
      check_eq("rst_done", obs_done(w), 0);
      check_eq("rst_pass", obs_pass(w), 0);
      check_eq("rst_err", obs_err(w), 0);
      check_eq("rst_fvec", obs_fvec(w), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n  = 1'b0;
      start0 = 1'b0;
      start1 = 1'b0;
      mode0  = M_AND;
      mode1  = M_XOR;
      #1;
      check_reset_state(0);
      check_reset_state(1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("idle_done", obs_done(0), 0);

      run_sweep(0, M_AND, 1'b0);
      run_sweep(0, M_TIE0, 1'b0);
      run_sweep(0, M_TIE1, 1'b0);
      run_sweep(0, M_AND, 1'b1);
      run_sweep(0, M_AND, 1'b0);
      run_sweep(1, M_XOR, 1'b0);
      run_sweep(1, M_TIE0, 1'b0);
      run_sweep(1, M_TIE1, 1'b0);

      // Reset in the middle of a sweep: everything clears immediately.
      @(negedge clk);
`ifdef GATE_BIST_STOP_ON_FAIL_EN
      mode0 = M_AND;
`else
      mode0 = M_TIE1;
`endif
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("pre_rst_dut_in", obs_din(0), 2);
`ifdef GATE_BIST_STOP_ON_FAIL_EN
      check_eq("pre_rst_err", obs_err(0), 0);
`else
      check_eq("pre_rst_err", obs_err(0), 2);
`endif
      check_eq("pre_rst_busy", obs_busy(0), 1);
      rst_n = 1'b0;
      #1;
      check_reset_state(0);
      @(negedge clk);
      rst_n = 1'b1;
      run_sweep(0, M_AND, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
